// File: rtl/truth_table_sweeper.sv
// Walks x through all 128 input patterns of a 7-input combinational function,
// capturing f for each pattern into a truth table and keeping a running popcount.
module truth_table_sweeper #(
  parameter int SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         f,
  output logic [6:0]   x,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [127:0] tt,
  output logic [7:0]   ones
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle counter reload; unused when SETTLE is zero.
  localparam logic [3:0] RELOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam bit HAS_SETTLE = (SETTLE > 0);

  state_t       state_reg, state_next;
  logic [6:0]   idx_reg, idx_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic         valid_reg, valid_next;
  logic [127:0] tt_reg;
  logic [7:0]   ones_reg;
  logic         clear;
  logic         sample_en;
  logic [127:0] bit_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 7'd0;
      cnt_reg   <= 4'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    clear      = 1'b0;
    sample_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          idx_next   = 7'd0;
          valid_next = 1'b0;
          if (HAS_SETTLE) begin
            state_next = WAIT;
            cnt_next   = RELOAD;
          end else begin
            state_next = SAMPLE;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (idx_reg == 7'd127) begin
          state_next = DONE;
          valid_next = 1'b1;
        end else begin
          idx_next = idx_reg + 7'd1;
          if (HAS_SETTLE) begin
            state_next = WAIT;
            cnt_next   = RELOAD;
          end else begin
            state_next = SAMPLE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot write enable for the truth-table bit addressed by idx.
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_sel
      assign bit_sel[gi] = sample_en && (idx_reg == 7'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tt_reg   <= '0;
      ones_reg <= 8'd0;
    end else if (sample_en) begin
      tt_reg   <= (tt_reg & ~bit_sel) | (bit_sel & {128{f}});
      ones_reg <= ones_reg + {7'd0, f};
    end
  end

  assign x     = (state_reg == IDLE) ? 7'd0 : idx_reg;
  assign busy  = (state_reg == WAIT) || (state_reg == SAMPLE);
  assign done  = (state_reg == DONE);
  assign valid = valid_reg;
  assign tt    = tt_reg;
  assign ones  = ones_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus queues expected sweep results, a monitor checks each done pulse.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic         rst0, start0, f0, busy0, done0, valid0;
  logic [6:0]   x0;
  logic [127:0] tt0;
  logic [7:0]   ones0;
  logic         rst1, start1, f1, busy1, done1, valid1;
  logic [6:0]   x1;
  logic [127:0] tt1;
  logic [7:0]   ones1;

  int mode0 = 0;
  always_comb begin
    case (mode0)
      0:       f0 = x0[0];
      1:       f0 = &x0;
      2:       f0 = 1'b1;
      default: f0 = 1'b0;
    endcase
  end
  assign f1 = x1[6];

  truth_table_sweeper #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .f(f0), .x(x0),
    .busy(busy0), .done(done0), .valid(valid0), .tt(tt0), .ones(ones0)
  );

  truth_table_sweeper #(.SETTLE(3)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .f(f1), .x(x1),
    .busy(busy1), .done(done1), .valid(valid1), .tt(tt1), .ones(ones1)
  );

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    int           done_at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int dones0 = 0;
  int dones1 = 0;

  localparam logic [127:0] TT_X0   = {32{4'hA}};
  localparam logic [127:0] TT_AND  = {1'b1, 127'd0};
  localparam logic [127:0] TT_ONES = {128{1'b1}};
  localparam logic [127:0] TT_X6   = {{64{1'b1}}, {64{1'b0}}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        dones0++;
        if (q0.size() == 0) begin
          check("dut0_unexpected_done", 128'(cyc), 128'(0));
        end else begin
          e = q0.pop_front();
          $display("[TB] dut0 done at edge %0d ones=%0d tt=%h", cyc, ones0, tt0);
          check("dut0_tt", tt0, e.tt);
          check("dut0_ones", 128'(ones0), 128'(e.ones));
          check("dut0_valid", 128'(valid0), 128'(1));
          check("dut0_done_edge", 128'(cyc), 128'(e.done_at));
        end
      end
      if (done1 === 1'b1) begin
        dones1++;
        if (q1.size() == 0) begin
          check("dut1_unexpected_done", 128'(cyc), 128'(0));
        end else begin
          e = q1.pop_front();
          $display("[TB] dut1 done at edge %0d ones=%0d tt=%h", cyc, ones1, tt1);
          check("dut1_tt", tt1, e.tt);
          check("dut1_ones", 128'(ones1), 128'(e.ones));
          check("dut1_valid", 128'(valid1), 128'(1));
          check("dut1_done_edge", 128'(cyc), 128'(e.done_at));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_sweep0(input logic [127:0] ett, input logic [7:0] eones, input bit expect_result);
    exp_t e;
    start0 = 1'b1;
    if (expect_result) begin
      e.tt = ett; e.ones = eones; e.done_at = cyc + 1 + 128;
      q0.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
    check(name, 128'(seen), 128'(1));
  endtask

  initial begin
    exp_t e;
    int bad;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("rst_busy", 128'(busy0), 128'(0));
    check("rst_done", 128'(done0), 128'(0));
    check("rst_valid", 128'(valid0), 128'(0));
    check("rst_tt", tt0, 128'(0));
    check("rst_ones", 128'(ones0), 128'(0));
    check("rst_x", 128'(x0), 128'(0));
    check("rst_x_dut1", 128'(x1), 128'(0));

    // f = x[0], with an ignored start pulse during cycle 50.
    mode0 = 0;
    start_sweep0(TT_X0, 8'd64, 1'b1);
    check("a_busy", 128'(busy0), 128'(1));
    check("a_valid_cleared", 128'(valid0), 128'(0));
    check("a_x_first", 128'(x0), 128'(0));
    repeat (49) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("a_x_at_50", 128'(x0), 128'(50));
    check("a_busy_at_50", 128'(busy0), 128'(1));
    repeat (80) @(negedge clk);
    check("a_idle_valid", 128'(valid0), 128'(1));
    check("a_idle_busy", 128'(busy0), 128'(0));
    check("a_idle_x", 128'(x0), 128'(0));
    check("a_idle_tt", tt0, TT_X0);

    // f = AND of all bits, then f = 1.
    mode0 = 1;
    start_sweep0(TT_AND, 8'd1, 1'b1);
    repeat (131) @(negedge clk);
    mode0 = 2;
    start_sweep0(TT_ONES, 8'd128, 1'b1);
    repeat (131) @(negedge clk);

    // Mid-sweep reset at cycle 70, then a normal sweep.
    mode0 = 0;
    start_sweep0(128'(0), 8'd0, 1'b0);
    repeat (69) @(negedge clk);
    check("d_busy_before_rst", 128'(busy0), 128'(1));
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("d_rst_busy", 128'(busy0), 128'(0));
    check("d_rst_valid", 128'(valid0), 128'(0));
    check("d_rst_tt", tt0, 128'(0));
    check("d_rst_ones", 128'(ones0), 128'(0));
    check("d_rst_x", 128'(x0), 128'(0));
    repeat (2) @(negedge clk);
    start_sweep0(TT_X0, 8'd64, 1'b1);
    repeat (131) @(negedge clk);

    // Back-to-back sweeps with start held high: f = x[0], then f = 0.
    mode0 = 0;
    start0 = 1'b1;
    e.tt = TT_X0; e.ones = 8'd64; e.done_at = cyc + 1 + 128;
    q0.push_back(e);
    e.tt = 128'(0); e.ones = 8'd0; e.done_at = cyc + 1 + 258;
    q0.push_back(e);
    wait_done0("e_first_done_seen");
    mode0 = 3;
    @(negedge clk);
    check("e_gap_valid", 128'(valid0), 128'(1));
    check("e_gap_busy", 128'(busy0), 128'(0));
    @(negedge clk);
    check("e_second_valid_drop", 128'(valid0), 128'(0));
    check("e_second_busy", 128'(busy0), 128'(1));
    wait_done0("e_second_done_seen");
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("e_no_third_sweep", 128'(busy0), 128'(0));
    check("e_final_valid", 128'(valid0), 128'(1));

    // SETTLE = 3, f = x[6]; each pattern must hold x for four cycles.
    start1 = 1'b1;
    e.tt = TT_X6; e.ones = 8'd64; e.done_at = cyc + 1 + 512;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    bad = 0;
    for (int j = 0; j < 512; j++) begin
      if (x1 !== 7'(j / 4) || busy1 !== 1'b1) bad++;
      @(negedge clk);
    end
    check("f_x_hold_4_cycles", 128'(bad), 128'(0));
    repeat (3) @(negedge clk);

    check("q0_drained", 128'(q0.size()), 128'(0));
    check("q1_drained", 128'(q1.size()), 128'(0));
    check("dut0_done_count", 128'(dones0), 128'(6));
    check("dut1_done_count", 128'(dones1), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
